// File: rtl/cfg_loader_pkg.sv
// Shared types and field map for the PS-PWM serial configuration loader.
// The field constants describe the default 11-bit configuration word layout.
package cfg_loader_pkg;

  localparam int DEFAULT_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_PARITY   = 2'd2,
    ST_WAIT_END = 2'd3
  } cfg_state_e;

  // Field map of the 11-bit word: dead-time, two generator selectors, output selector
  localparam int DT_LSB       = 0;
  localparam int DT_W         = 5;
  localparam int SEL_GEN1_LSB = 5;
  localparam int SEL_GEN2_LSB = 7;
  localparam int OUT_SEL_LSB  = 9;
  localparam int SEL_W        = 2;

endpackage

// File: rtl/cfg_serial_loader.sv
// Serial configuration loader: shifts a framed bitstream into a shadow register and
// commits it to cfg_out in one edge once the frame is complete and its parity is good.
module cfg_serial_loader
  import cfg_loader_pkg::*;
#(
  parameter int                 WIDTH       = DEFAULT_WIDTH,
  parameter int                 PARITY_EN   = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                CW          = $clog2(WIDTH + 1)
) (
  input  logic             CLK_SR,
  input  logic             RST,
  input  logic             load_en,
  input  logic             data_in,
  output logic [WIDTH-1:0] cfg_out,
  output logic             cfg_update,
  output logic             busy,
  output logic             frame_err,
  output logic [CW-1:0]    bit_count
);

  localparam logic [1:0]    S_IDLE     = 2'(ST_IDLE);
  localparam logic [1:0]    S_SHIFT    = 2'(ST_SHIFT);
  localparam logic [1:0]    S_PARITY   = 2'(ST_PARITY);
  localparam logic [1:0]    S_WAIT_END = 2'(ST_WAIT_END);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shadow;
  logic             parity_acc;

  assign busy = (state == S_SHIFT) || (state == S_PARITY);

  always_ff @(posedge CLK_SR or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      shadow     <= '0;
      bit_count  <= '0;
      cfg_out    <= RESET_VALUE;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      parity_acc <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_en) begin
            shadow     <= {{(WIDTH-1){1'b0}}, data_in};
            bit_count  <= CW'(1);
            parity_acc <= data_in;
            frame_err  <= 1'b0;
            state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (load_en) begin
            // shadow was cleared at frame start, so OR-ing the bit in places it
            shadow     <= shadow | (WIDTH'(data_in) << bit_count);
            bit_count  <= bit_count + CW'(1);
            parity_acc <= parity_acc ^ data_in;
            if (bit_count == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
              end else begin
                cfg_out    <= {data_in, shadow[WIDTH-2:0]};
                cfg_update <= 1'b1;
                state      <= S_WAIT_END;
              end
            end
          end else begin
            frame_err <= 1'b1;
            shadow    <= '0;
            state     <= S_IDLE;
          end
        end
        S_PARITY: begin
          if (load_en) begin
            if ((parity_acc ^ data_in) == 1'b0) begin
              cfg_out    <= shadow;
              cfg_update <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= S_WAIT_END;
          end else begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_WAIT_END: begin
          // Bits beyond the frame are an overrun; the committed word stays
          if (load_en) frame_err <= 1'b1;
          else         state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
